game_flow_controller: RTL and testbench
=======================================

// Module: game_flow_controller
// PURPOSE
//  Top-level sequencer for one game session: gates the per-frame enable of the player and enemy datapaths,
//  pauses/resumes play, advances levels and ends the game. It sits between the keyboard key decoders and
//  the player/enemy blocks. It drives their enable inputs, a one-cycle restart pulse and the level index.
//  All timing is in frames, counted on startOfFrame.
// PARAMETERS
//  LEVEL_WIDTH      3    width of the level index
//  LAST_LEVEL       3    highest level; clearing it ends the game in WIN
//  BANNER_FRAMES    120  frames the LEVEL_CLEAR / GAME_OVER / WIN banner is held
//  FRAME_CNT_WIDTH  8    width of the frame countdown; must hold BANNER_FRAMES
// PORTS
//  clk               in   1            system clock
//  reset             in   1            synchronous, active-high reset
//  startOfFrame      in   1            one-cycle pulse per video frame
//  start_key         in   1            level: start/continue key is pressed
//  pause_key         in   1            level: pause key is pressed
//  player_dead       in   1            level: player has no lives left
//  enemies_cleared   in   1            level: every enemy of the current level is destroyed
//  player_enable     out  1            frame-tick gate for the player datapath
//  enemies_enable    out  1            frame-tick gate for the enemy datapath
//  restart_pulse     out  1            one-cycle pulse; re-initialises player and enemies
//  level             out  LEVEL_WIDTH  current level, 0-based
//  banner_code       out  2            0 none, 1 level clear, 2 game over, 3 win
//  game_state        out  3            encoded current state (debug/HUD)
// BEHAVIOUR
//  - Reset values: state IDLE, level 0, both enables 0, restart_pulse 0, banner_code 0, frame counter 0.
//  - Key inputs are internally edge-detected (rising edge = press). A key held through reset does not
//    count as a press.
//  - States and transitions (one per clk; listed in priority order):
//    IDLE        : start press -> PLAY, restart_pulse=1, level=0.
//    PLAY        : player_dead -> GAME_OVER;
//                  else enemies_cleared -> LEVEL_CLEAR (or WIN if level==LAST_LEVEL);
//                  else pause press -> PAUSED.
//    PAUSED      : pause or start press -> PLAY. No restart; datapath state is preserved.
//    LEVEL_CLEAR : counter loaded with BANNER_FRAMES-1 on entry and decremented on each startOfFrame.
//                  At 0 with startOfFrame -> PLAY, level+1, restart_pulse=1.
//    GAME_OVER/WIN: counter as above. Once it has expired, a start press -> IDLE. Presses before expiry
//                  are ignored.
//  - player_dead and enemies_cleared asserted in the same cycle: GAME_OVER wins.
//  - player_enable = enemies_enable = 1 only in PLAY. Both are registered, so they drop in the same cycle
//    the state leaves PLAY and rise in the cycle after restart_pulse.
//  - restart_pulse is registered and lasts exactly one clk. It never coincides with an enable being 1.
//  - banner_code: 1 in LEVEL_CLEAR, 2 in GAME_OVER, 3 in WIN, otherwise 0.
//  - level saturates at LAST_LEVEL and never wraps.
//  - player_dead / enemies_cleared are ignored outside PLAY.
//  - Synchronous reset mid-banner or mid-pause returns to IDLE on the next edge. No pulse is emitted.
// STRUCTURE
//  - Shared package: game_state_t enum (IDLE, PLAY, PAUSED, LEVEL_CLEAR, GAME_OVER, WIN) and the
//    banner_code constants, reused by the HUD/text renderer.
//  - Sub-module frame_timer: load / countdown-on-startOfFrame / expired flag. It is reused by the banner
//    logic and is a candidate for other frame delays.
//  - Key edge detection stays local.
// TESTING
//  1 Reset, then start press -> one restart_pulse. The next cycle has player_enable=enemies_enable=1,
//    level=0, banner_code=0.
//  2 In PLAY, pause press -> enables 0, state PAUSED. 10 frames later, pause press -> enables 1 again
//    with no restart_pulse.
//  3 In PLAY at level 0, enemies_cleared -> banner_code=1. After exactly 120 startOfFrame pulses:
//    restart_pulse, level=1, enables 1.
//  4 Same cycle player_dead=1 and enemies_cleared=1 -> GAME_OVER, banner_code=2. A start press at frame 50
//    is ignored. A start press after frame 120 -> IDLE.
//  5 At level 3 (LAST_LEVEL), enemies_cleared -> WIN, banner_code=3, and level stays 3.
//  6 reset asserted during LEVEL_CLEAR with counter=60 -> next edge IDLE, level 0, all outputs at reset values.

Source files
------------

// File: rtl/game_flow_controller_pkg.sv
// Shared game-session types: session state encoding and banner codes, also used by the HUD/text renderer.
package game_flow_controller_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    PLAY        = 3'd1,
    PAUSED      = 3'd2,
    LEVEL_CLEAR = 3'd3,
    GAME_OVER   = 3'd4,
    WIN         = 3'd5
  } game_state_t;

  localparam logic [1:0] BANNER_NONE        = 2'd0;
  localparam logic [1:0] BANNER_LEVEL_CLEAR = 2'd1;
  localparam logic [1:0] BANNER_GAME_OVER   = 2'd2;
  localparam logic [1:0] BANNER_WIN         = 2'd3;

  function automatic logic [1:0] banner_of(game_state_t s);
    case (s)
      LEVEL_CLEAR: banner_of = BANNER_LEVEL_CLEAR;
      GAME_OVER:   banner_of = BANNER_GAME_OVER;
      WIN:         banner_of = BANNER_WIN;
      default:     banner_of = BANNER_NONE;
    endcase
  endfunction

endpackage

// File: rtl/game_flow_controller_if.sv
// Signal bundle between the key decoders / player / enemy blocks and the game flow controller.
interface game_flow_controller_if #(
  parameter int LEVEL_WIDTH = 3
);
  logic                   startOfFrame;
  logic                   start_key;
  logic                   pause_key;
  logic                   player_dead;
  logic                   enemies_cleared;
  logic                   player_enable;
  logic                   enemies_enable;
  logic                   restart_pulse;
  logic [LEVEL_WIDTH-1:0] level;
  logic [1:0]             banner_code;
  logic [2:0]             game_state;

  modport master (
    output startOfFrame, start_key, pause_key, player_dead, enemies_cleared,
    input  player_enable, enemies_enable, restart_pulse, level, banner_code, game_state
  );

  modport slave (
    input  startOfFrame, start_key, pause_key, player_dead, enemies_cleared,
    output player_enable, enemies_enable, restart_pulse, level, banner_code, game_state
  );
endinterface

// File: rtl/game_flow_controller_frame_timer.sv
// Frame countdown: load, decrement on each frame tick, and a sticky expired flag set by the tick seen at zero.
module frame_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             tick,
  output logic             expire_now,
  output logic             expired
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             expired_q, expired_d;

  assign expire_now = tick & (count_q == '0);
  assign expired    = expired_q;

  always_comb begin
    count_d   = count_q;
    expired_d = expired_q;
    if (load) begin
      count_d   = load_value;
      expired_d = 1'b0;
    end else if (tick) begin
      if (count_q != '0) count_d = count_q - 1'b1;
      else               expired_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      expired_q <= expired_d;
    end
  end

endmodule

// File: rtl/game_flow_controller.sv
// Game session sequencer: gates player/enemy frame enables, handles pause, level advance and end-of-game banners.
module game_flow_controller
  import game_flow_controller_pkg::*;
#(
  parameter int LEVEL_WIDTH     = 3,
  parameter int LAST_LEVEL      = 3,
  parameter int BANNER_FRAMES   = 120,
  parameter int FRAME_CNT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  game_flow_controller_if.slave bus
);

  localparam logic [LEVEL_WIDTH-1:0]     LAST_LVL    = LEVEL_WIDTH'(LAST_LEVEL);
  localparam logic [FRAME_CNT_WIDTH-1:0] BANNER_LOAD = FRAME_CNT_WIDTH'(BANNER_FRAMES - 1);

  game_state_t            state_q, state_d;
  logic [LEVEL_WIDTH-1:0] level_q, level_d;
  logic                   restart_q, restart_d;
  logic                   enable_q, enable_d;
  logic                   start_prev_q, pause_prev_q;
  logic                   start_press, pause_press;
  logic                   timer_load, timer_expire_now, timer_expired;

  // Previous key levels are sampled through reset so a key held across reset is not seen as a press.
  always_ff @(posedge clk) begin
    start_prev_q <= bus.start_key;
    pause_prev_q <= bus.pause_key;
  end

  assign start_press = bus.start_key & ~start_prev_q;
  assign pause_press = bus.pause_key & ~pause_prev_q;

  frame_timer #(
    .WIDTH(FRAME_CNT_WIDTH)
  ) u_banner_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (BANNER_LOAD),
    .tick       (bus.startOfFrame),
    .expire_now (timer_expire_now),
    .expired    (timer_expired)
  );

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    restart_d  = 1'b0;
    timer_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_press) begin
          state_d   = PLAY;
          restart_d = 1'b1;
          level_d   = '0;
        end
      end
      PLAY: begin
        if (bus.player_dead) begin
          state_d    = GAME_OVER;
          timer_load = 1'b1;
        end else if (bus.enemies_cleared) begin
          state_d    = (level_q == LAST_LVL) ? WIN : LEVEL_CLEAR;
          timer_load = 1'b1;
        end else if (pause_press) begin
          state_d = PAUSED;
        end
      end
      PAUSED: begin
        if (pause_press || start_press) state_d = PLAY;
      end
      LEVEL_CLEAR: begin
        if (timer_expire_now) begin
          state_d   = PLAY;
          restart_d = 1'b1;
          level_d   = (level_q >= LAST_LVL) ? LAST_LVL : level_q + 1'b1;
        end
      end
      GAME_OVER, WIN: begin
        if (timer_expired && start_press) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Enables follow the next state but stay low while the restart pulse is out.
    enable_d = (state_d == PLAY) && !restart_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      level_q   <= '0;
      restart_q <= 1'b0;
      enable_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      restart_q <= restart_d;
      enable_q  <= enable_d;
    end
  end

  assign bus.player_enable  = enable_q;
  assign bus.enemies_enable = enable_q;
  assign bus.restart_pulse  = restart_q;
  assign bus.level          = level_q;
  assign bus.banner_code    = banner_of(state_q);
  assign bus.game_state     = state_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Bench for game_flow_controller: directed session scenarios plus random stimulus against a frame-counting reference model.
module tb_game_flow_controller;
  import game_flow_controller_pkg::*;

  localparam int LW = 3;
  localparam int LAST = 3;
  localparam int BF = 120;
  localparam int FW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  game_flow_controller_if #(.LEVEL_WIDTH(LW)) bus ();

  game_flow_controller #(
    .LEVEL_WIDTH(LW), .LAST_LEVEL(LAST), .BANNER_FRAMES(BF), .FRAME_CNT_WIDTH(FW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: counts banner frames upward and tracks whether a restart was just issued.
  game_state_t m_mode;
  int m_level, m_frames;
  bit m_restart, m_en, m_prev_start, m_prev_pause;

  function automatic int exp_banner(game_state_t s);
    if (s == LEVEL_CLEAR) return 1;
    if (s == GAME_OVER) return 2;
    if (s == WIN) return 3;
    return 0;
  endfunction

  task automatic model_step();
    bit sp, pp, rs;
    game_state_t nm;
    sp = bus.start_key && !m_prev_start;
    pp = bus.pause_key && !m_prev_pause;
    m_prev_start = bus.start_key;
    m_prev_pause = bus.pause_key;
    if (reset) begin
      m_mode = IDLE; m_level = 0; m_frames = 0; m_restart = 0; m_en = 0;
      return;
    end
    rs = 0;
    nm = m_mode;
    if (m_mode == IDLE) begin
      if (sp) begin nm = PLAY; rs = 1; m_level = 0; end
    end else if (m_mode == PLAY) begin
      if (bus.player_dead) begin nm = GAME_OVER; m_frames = 0; end
      else if (bus.enemies_cleared) begin nm = (m_level == LAST) ? WIN : LEVEL_CLEAR; m_frames = 0; end
      else if (pp) nm = PAUSED;
    end else if (m_mode == PAUSED) begin
      if (pp || sp) nm = PLAY;
    end else if (m_mode == LEVEL_CLEAR) begin
      if (bus.startOfFrame) begin
        m_frames++;
        if (m_frames == BF) begin
          nm = PLAY; rs = 1;
          m_level = (m_level + 1 > LAST) ? LAST : m_level + 1;
        end
      end
    end else begin
      if (sp && m_frames >= BF) nm = IDLE;
      else if (bus.startOfFrame && m_frames < BF) m_frames++;
    end
    m_mode = nm;
    m_restart = rs;
    m_en = (nm == PLAY) && !rs;
  endtask

  task automatic compare_all();
    chk("player_enable", int'(bus.player_enable), int'(m_en));
    chk("enemies_enable", int'(bus.enemies_enable), int'(m_en));
    chk("restart_pulse", int'(bus.restart_pulse), int'(m_restart));
    chk("level", int'(bus.level), m_level);
    chk("banner_code", int'(bus.banner_code), exp_banner(m_mode));
    chk("game_state", int'(bus.game_state), int'(m_mode));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic press_start();
    bus.start_key = 1'b1; step();
    bus.start_key = 1'b0; step();
  endtask

  task automatic press_pause();
    bus.pause_key = 1'b1; step();
    bus.pause_key = 1'b0; step();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      bus.startOfFrame = 1'b1; step();
      bus.startOfFrame = 1'b0; step();
    end
  endtask

  task automatic clear_level();
    bus.enemies_cleared = 1'b1; step();
    bus.enemies_cleared = 1'b0; step();
  endtask

  int seen;

  initial begin
    reset = 1'b1;
    bus.startOfFrame = 1'b0; bus.start_key = 1'b1; bus.pause_key = 1'b0;
    bus.player_dead = 1'b0; bus.enemies_cleared = 1'b0;
    m_prev_start = 1; m_prev_pause = 0;
    repeat (3) step();
    reset = 1'b0;
    repeat (3) step();
    chk("t1_held_key_idle", int'(bus.game_state), int'(IDLE));
    bus.start_key = 1'b0; step();

    // 1: start press -> single restart pulse, then enables
    bus.start_key = 1'b1; step();
    chk("t1_restart", int'(bus.restart_pulse), 1);
    chk("t1_en_during_restart", int'(bus.player_enable), 0);
    bus.start_key = 1'b0; step();
    chk("t1_restart_gone", int'(bus.restart_pulse), 0);
    chk("t1_enable", int'(bus.player_enable), 1);
    chk("t1_level", int'(bus.level), 0);

    // 2: pause, 10 frames, resume without restart
    press_pause();
    chk("t2_paused", int'(bus.game_state), int'(PAUSED));
    chk("t2_en_off", int'(bus.enemies_enable), 0);
    frames(10);
    press_pause();
    chk("t2_en_on", int'(bus.enemies_enable), 1);

    // 3: level clear held exactly 120 frames
    clear_level();
    chk("t3_banner", int'(bus.banner_code), 1);
    seen = 0;
    for (int i = 1; i <= 200 && seen == 0; i++) begin
      bus.startOfFrame = 1'b1; step();
      if (bus.restart_pulse) seen = i;
      bus.startOfFrame = 1'b0; step();
    end
    chk("t3_frames", seen, BF);
    chk("t3_level", int'(bus.level), 1);
    chk("t3_enable", int'(bus.player_enable), 1);

    // 4: dead and cleared together -> game over; early press ignored
    bus.player_dead = 1'b1; bus.enemies_cleared = 1'b1; step();
    bus.player_dead = 1'b0; bus.enemies_cleared = 1'b0; step();
    chk("t4_banner", int'(bus.banner_code), 2);
    frames(50);
    press_start();
    chk("t4_early_press", int'(bus.game_state), int'(GAME_OVER));
    frames(69);
    press_start();
    chk("t4_press_at_119", int'(bus.game_state), int'(GAME_OVER));
    frames(1);
    press_start();
    chk("t4_to_idle", int'(bus.game_state), int'(IDLE));

    // 5: reach last level and win
    press_start();
    for (int l = 0; l < LAST; l++) begin
      clear_level();
      frames(BF);
      step();
    end
    chk("t5_level3", int'(bus.level), 3);
    clear_level();
    chk("t5_win", int'(bus.banner_code), 3);
    chk("t5_level_kept", int'(bus.level), 3);
    frames(BF);
    press_start();
    chk("t5_idle", int'(bus.game_state), int'(IDLE));

    // 6: reset mid-banner
    press_start();
    clear_level();
    frames(59);
    reset = 1'b1; step();
    reset = 1'b0;
    chk("t6_state", int'(bus.game_state), int'(IDLE));
    chk("t6_level", int'(bus.level), 0);
    chk("t6_banner", int'(bus.banner_code), 0);
    chk("t6_restart", int'(bus.restart_pulse), 0);
    step();

    // Random phase
    for (int c = 0; c < 6000; c++) begin
      bus.startOfFrame    = ($urandom % 3) == 0;
      if (($urandom % 6) == 0) bus.start_key = ~bus.start_key;
      if (($urandom % 7) == 0) bus.pause_key = ~bus.pause_key;
      bus.player_dead     = ($urandom % 60) == 0;
      bus.enemies_cleared = ($urandom % 25) == 0;
      reset               = ($urandom % 900) == 0;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
